// File: rtl/alu_result_capture.sv
// Capture buffer for ALU results: a DEPTH-entry circular FIFO of {Alu_Op,C,O,Z,R}
// with registered 1-cycle read, sticky over/underflow flags and a Z=1 hit counter.
module alu_result_capture #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_en,
    input  logic [3:0]  Alu_Op,
    input  logic [31:0] R,
    input  logic        C,
    input  logic        O,
    input  logic        Z,
    input  logic        rd_en,
    output logic [38:0] dout,
    output logic        dout_valid,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty,
    output logic        ovf_err,
    output logic        udf_err,
    output logic [7:0]  zero_hits
);
    localparam int AW = $clog2(DEPTH);

    logic [38:0]   mem [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [4:0]    count_q, count_d;
    logic          full_q, empty_q;
    logic [38:0]   dout_q;
    logic          dv_q;
    logic          ovf_q, udf_q;
    logic [7:0]    zh_q;
    logic          cap_ok, rd_ok;

    // A full buffer still takes a capture when a read frees a slot in the same cycle.
    assign cap_ok = cap_en && (!full_q || rd_en);
    assign rd_ok  = rd_en && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({cap_ok, rd_ok})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cap_ok) mem[wp_q] <= {Alu_Op, C, O, Z, R};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            zh_q    <= '0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == 5'(DEPTH));
            empty_q <= (count_d == 5'd0);
            dv_q    <= rd_ok;
            if (cap_ok) wp_q <= wp_q + 1'b1;
            if (rd_ok) begin
                rp_q   <= rp_q + 1'b1;
                dout_q <= mem[rp_q];
            end
            if (cap_en && full_q && !rd_en) ovf_q <= 1'b1;
            if (rd_en && empty_q)           udf_q <= 1'b1;
            if (cap_ok && Z && zh_q != 8'hFF) zh_q <= zh_q + 8'd1;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign ovf_err    = ovf_q;
    assign udf_err    = udf_q;
    assign zero_hits  = zh_q;
endmodule

// File: tb/tb_alu_result_capture.sv
// Directed bench for alu_result_capture: queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_alu_result_capture;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cap_en = 1'b0, rd_en = 1'b0;
    logic [3:0]  Alu_Op = '0;
    logic [31:0] R = '0;
    logic        C = 1'b0, O = 1'b0, Z = 1'b0;
    logic [38:0] dout;
    logic        dout_valid, full, empty, ovf_err, udf_err;
    logic [4:0]  count;
    logic [7:0]  zero_hits;

    int checks = 0;
    int failures = 0;

    alu_result_capture #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cap_en(cap_en), .Alu_Op(Alu_Op), .R(R),
        .C(C), .O(O), .Z(Z), .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid),
        .count(count), .full(full), .empty(empty), .ovf_err(ovf_err),
        .udf_err(udf_err), .zero_hits(zero_hits)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue plus sticky flags.
    logic [38:0] mq[$];
    logic [38:0] m_dout;
    logic        m_dv, m_ovf, m_udf;
    int          m_zh;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_dout = '0; m_dv = 0; m_ovf = 0; m_udf = 0; m_zh = 0;
        end else begin
            bit was_full, was_empty, rd_ok, cap_ok;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            rd_ok  = rd_en && !was_empty;
            cap_ok = cap_en && (!was_full || rd_en);
            m_dv = rd_ok;
            if (rd_ok) m_dout = mq.pop_front();
            if (rd_en && was_empty) m_udf = 1;
            if (cap_en && was_full && !rd_en) m_ovf = 1;
            if (cap_ok) begin
                mq.push_back({Alu_Op, C, O, Z, R});
                if (Z && m_zh < 255) m_zh++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("count", 64'(count), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("dout_valid", 64'(dout_valid), 64'(m_dv));
        chk("dout", 64'(dout), 64'(m_dout));
        chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
        chk("udf_err", 64'(udf_err), 64'(m_udf));
        chk("zero_hits", 64'(zero_hits), 64'(m_zh));
    end

    // Drive one cycle of inputs (called just after a falling edge), return after the next falling edge.
    task automatic step(input bit cap, input logic [3:0] op, input logic [31:0] r,
                        input bit c, input bit o, input bit z, input bit rd);
        cap_en = cap; Alu_Op = op; R = r; C = c; O = o; Z = z; rd_en = rd;
        @(negedge clk);
        cap_en = 0; rd_en = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 64'(count), 0);
        chk({tag, "_empty"}, 64'(empty), 1);
        chk({tag, "_full"}, 64'(full), 0);
        chk({tag, "_dout"}, 64'(dout), 0);
        chk({tag, "_dv"}, 64'(dout_valid), 0);
        chk({tag, "_ovf"}, 64'(ovf_err), 0);
        chk({tag, "_udf"}, 64'(udf_err), 0);
        chk({tag, "_zh"}, 64'(zero_hits), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_state("por");
        reset = 1'b1;

        // Single capture then read: packing and one-cycle valid pulse.
        step(1, 4'h1, 32'h6E, 0, 0, 0, 0);
        chk("cap1_count", 64'(count), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rd1_dout", 64'(dout), 64'h08_0000006E);
        chk("rd1_dv", 64'(dout_valid), 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rd1_dv_drop", 64'(dout_valid), 0);
        chk("rd1_hold", 64'(dout), 64'h08_0000006E);

        // Fill with Alu_Op 1..8, mixed flags.
        for (int i = 1; i <= 8; i++)
            step(1, 4'(i), 32'h1000 + 32'(i), i[0], i[1], i[2], 0);
        chk("fill_count", 64'(count), 8);
        chk("fill_full", 64'(full), 1);

        // Capture while full: dropped without read, accepted with read.
        step(1, 4'h9, 32'hDEAD, 0, 0, 0, 0);
        chk("drop_ovf", 64'(ovf_err), 1);
        chk("drop_count", 64'(count), 8);
        step(1, 4'hA, 32'hBEEF, 1, 1, 1, 1);
        chk("fullrw_count", 64'(count), 8);
        chk("fullrw_op", 64'(dout[38:35]), 1);

        // Drain: ops 2..8 then the 0xA entry.
        for (int i = 2; i <= 8; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            chk("drain_op", 64'(dout[38:35]), 64'(i));
        end
        step(0, 0, 0, 0, 0, 0, 1);
        chk("drain_last", 64'(dout), {25'd0, 4'hA, 3'b111, 32'hBEEF});
        chk("drain_empty", 64'(empty), 1);

        // Read on empty: refused, dout held; a same-cycle capture still lands.
        step(0, 0, 0, 0, 0, 0, 1);
        chk("udf_flag", 64'(udf_err), 1);
        chk("udf_dv", 64'(dout_valid), 0);
        chk("udf_hold", 64'(dout[31:0]), 32'hBEEF);
        step(1, 4'h3, 32'h0, 0, 0, 1, 1);
        chk("udf_cap_count", 64'(count), 1);

        // Long Z=1 stream with concurrent reads: zero_hits saturates at 255.
        for (int i = 0; i < 300; i++)
            step(1, 4'(i), 32'(i), 0, 0, 1, 1);
        chk("zh_sat", 64'(zero_hits), 255);
        step(0, 0, 0, 0, 0, 0, 1);

        // Wrap pointers a few times with varied data.
        for (int i = 0; i < 20; i++)
            step((i % 3) != 2, 4'(i), 32'hA5A5_0000 ^ 32'(i * 7), i[0], i[2], 0, (i % 2) == 1);

        // Build count=5 then reset mid-cycle: outputs clear before any edge.
        while (count != 0) step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 4'(i), 32'(i), 0, 0, 1, 0);
        chk("pre_rst_count", 64'(count), 5);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_state("async");
        @(negedge clk);
        reset = 1'b1;

        // First edge after reset works normally.
        step(1, 4'h7, 32'h1234_5678, 1, 0, 0, 0);
        chk("post_rst_count", 64'(count), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("post_rst_dout", 64'(dout), {25'd0, 4'h7, 3'b100, 32'h1234_5678});

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_result_capture.md
ALU_RESULT_CAPTURE -- requirements
Module: alu_result_capture

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 8, the number of capture entries, a power of two from 2 to 16.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port cap_en, input, 1 bit: capture strobe, one entry per high cycle.
REQ-005 The block SHALL have the port Alu_Op, input, 4 bits: the ALU operation code being captured.
REQ-006 The block SHALL have the port R, input, 32 bits: the ALU result.
REQ-007 The block SHALL have the ports C, O and Z, input, 1 bit each: the ALU carry, overflow and zero flags.
REQ-008 The block SHALL have the port rd_en, input, 1 bit: read request from the consumer.
REQ-009 The block SHALL have the port dout, output, 39 bits: the read entry, packed as {Alu_Op[3:0], C, O, Z, R[31:0]}, registered.
REQ-010 The block SHALL have the port dout_valid, output, 1 bit: one-cycle pulse, high while dout holds newly read data.
REQ-011 The block SHALL have the port count, output, 5 bits: the current number of stored entries.
REQ-012 The block SHALL have the ports full and empty, output, 1 bit each: count==DEPTH and count==0 respectively.
REQ-013 The block SHALL have the port ovf_err, output, 1 bit: sticky flag, set when a capture is dropped.
REQ-014 The block SHALL have the port udf_err, output, 1 bit: sticky flag, set when a read is refused.
REQ-015 The block SHALL have the port zero_hits, output, 8 bits: a saturating count of accepted captures with Z=1.

Function
REQ-016 The block SHALL implement storage as a circular buffer of DEPTH x 39 bits, with write pointer wp, read pointer rp and count.
REQ-017 A capture SHALL be accepted when cap_en=1 and either full=0, or full=1 and rd_en=1 in the same cycle.
REQ-018 An accepted capture SHALL write {Alu_Op,C,O,Z,R} at wp and advance wp modulo DEPTH.
REQ-019 The entry written by an accepted capture SHALL be readable no earlier than the following cycle.
REQ-020 A read SHALL be accepted when rd_en=1 and empty=0.
REQ-021 An accepted read SHALL load the entry at rp into dout, assert dout_valid on the next cycle, and advance rp modulo DEPTH.
REQ-022 The read latency SHALL be exactly 1 cycle.
REQ-023 dout SHALL hold its value between reads; dout_valid SHALL be low on every cycle that does not follow an accepted read.
REQ-024 When cap_en=1, full=1 and rd_en=0, the capture SHALL be dropped, storage SHALL be unchanged, and ovf_err SHALL be set.
REQ-025 When rd_en=1 and empty=1, the read SHALL be refused, dout SHALL be unchanged, dout_valid SHALL stay 0, and udf_err SHALL be set; a capture in the same cycle still proceeds.
REQ-026 When a capture and a read are both accepted in one cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-027 Otherwise count SHALL change by +1 per accepted capture and -1 per accepted read.
REQ-028 Pointer wrap SHALL occur from DEPTH-1 to 0 with no change to the count rule.
REQ-029 zero_hits SHALL increment on each accepted capture with Z=1 and SHALL saturate at 255.
REQ-030 ovf_err and udf_err SHALL clear only on reset.
REQ-031 full, empty and count SHALL be registered, and SHALL be consistent with one another on every cycle.

Reset
REQ-032 On reset=0, asynchronously: wp=rp=0, count=0, empty=1, full=0, dout=0, dout_valid=0, ovf_err=0, udf_err=0, zero_hits=0.
REQ-033 Storage contents need not be cleared on reset.
REQ-034 A capture or read in progress when reset asserts SHALL be discarded.
REQ-035 After reset deasserts, the first rising edge SHALL accept operations normally.

Verification
REQ-036 Scenario: capture Alu_Op=1, R=0x0000006E, C=O=Z=0, then rd_en -> next cycle dout=0x08_0000006E style packing {4'h1,3'b000,32'h6E}, dout_valid=1 for exactly 1 cycle.
REQ-037 Scenario: 8 captures with Alu_Op=1..8 -> full=1, count=8; reading 8 times returns Alu_Op 1..8 in order, then empty=1.
REQ-038 Scenario: 9th capture while full with rd_en=0 -> dropped, ovf_err=1, count stays 8; same cycle with rd_en=1 -> accepted, count stays 8.
REQ-039 Scenario: rd_en on empty -> udf_err=1, dout_valid=0, dout unchanged.
REQ-040 Scenario: 300 captures with Z=1, interleaved with reads -> zero_hits=255.
REQ-041 Scenario: reset pulsed low mid-stream with count=5 -> all outputs at reset values immediately, without waiting for clk.
